// File: rtl/rx_corr_reader.sv
`default_nettype none
// ============================================================================
// Module   : rx_corr_reader
// Purpose  : Consumer end of the rx_correlator_buff readout interface. After a
//            detector trigger it selects the sequence, enables storage wash,
//            pulls NSAMPLES correlation samples through a ready/ack handshake
//            and reports the correlation peak with both neighbouring samples.
// Ports    : crx_clk / rrx_rst (sync, active-high) / erx_en (freeze when low)
//            idetect_trigger, idetect_seq        - acquisition request
//            icorr_sample, icorr_sample_ready    - sample stream from buffer
//            oreceived_seq, ostorage_wash_enable,
//            onext_sample_trigger, oall_acquired_trigg - buffer control
//            obusy, oerror                       - status
//            opeak_valid, opeak_index, opeak_value,
//            opeak_prev, opeak_next              - peak results
// Config   : define RX_CORR_READER_ABS_EN to compare peaks by magnitude |s|
//            (most negative value saturates to the most positive one).
// Revision : 1.0 - initial release
// ============================================================================
module rx_corr_reader #(
  parameter int SAMPLE_W       = 32,
  parameter int NSAMPLES       = 128,
  parameter int IDX_W          = 7,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                crx_clk,
  input  logic                rrx_rst,
  input  logic                erx_en,
  input  logic                idetect_trigger,
  input  logic [3:0]          idetect_seq,
  input  logic [SAMPLE_W-1:0] icorr_sample,
  input  logic                icorr_sample_ready,
  output logic [3:0]          oreceived_seq,
  output logic                ostorage_wash_enable,
  output logic                onext_sample_trigger,
  output logic                oall_acquired_trigg,
  output logic                obusy,
  output logic                opeak_valid,
  output logic [IDX_W-1:0]    opeak_index,
  output logic [SAMPLE_W-1:0] opeak_value,
  output logic [SAMPLE_W-1:0] opeak_prev,
  output logic [SAMPLE_W-1:0] opeak_next,
  output logic                oerror
);

  // Sample counter needs one extra bit so it can reach NSAMPLES itself.
  localparam int c_cnt_w = IDX_W + 1;
  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_nsamples = c_cnt_w'(NSAMPLES);
  localparam logic [c_to_w-1:0]  c_timeout  = c_to_w'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                      r_state;
  logic [c_cnt_w-1:0]          r_cnt;
  logic [c_to_w-1:0]           r_to_cnt;
  logic signed [SAMPLE_W-1:0]  r_last;      // previously captured sample
  logic signed [SAMPLE_W-1:0]  r_max_key;   // comparison key of current max
  logic                        r_need_next; // next capture fills opeak_next

  logic signed [SAMPLE_W-1:0]  w_sample;
  logic signed [SAMPLE_W-1:0]  w_key;
  logic                        w_new_max;

  assign w_sample = $signed(icorr_sample);

`ifdef RX_CORR_READER_ABS_EN
  localparam logic signed [SAMPLE_W-1:0] c_smin = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] c_smax = {1'b0, {(SAMPLE_W-1){1'b1}}};

  // Magnitude key; the most negative value has no positive twin, so it
  // saturates and ties with the most positive value.
  always_comb begin
    w_key = w_sample;
    if (w_sample == c_smin) begin
      w_key = c_smax;
    end else if (w_sample[SAMPLE_W-1]) begin
      w_key = -w_sample;
    end
  end
`else
  assign w_key = w_sample;
`endif

  // Strictly greater: on ties the earliest sample keeps the peak.
  assign w_new_max = (w_key > r_max_key);

  always_ff @(posedge crx_clk) begin
    if (rrx_rst) begin
      r_state              <= IDLE;
      r_cnt                <= '0;
      r_to_cnt             <= '0;
      r_last               <= '0;
      r_max_key            <= '0;
      r_need_next          <= 1'b0;
      oreceived_seq        <= '0;
      ostorage_wash_enable <= 1'b0;
      onext_sample_trigger <= 1'b0;
      oall_acquired_trigg  <= 1'b0;
      obusy                <= 1'b0;
      opeak_valid          <= 1'b0;
      opeak_index          <= '0;
      opeak_value          <= '0;
      opeak_prev           <= '0;
      opeak_next           <= '0;
      oerror               <= 1'b0;
    end else if (erx_en) begin
      case (r_state)
        IDLE: begin
          if (idetect_trigger) begin
            oreceived_seq <= idetect_seq;
            oerror        <= 1'b0;
            obusy         <= 1'b1;
            opeak_index   <= '0;
            opeak_value   <= '0;
            opeak_prev    <= '0;
            opeak_next    <= '0;
            r_max_key     <= '0;
            r_need_next   <= 1'b0;
            r_cnt         <= '0;
            r_to_cnt      <= '0;
            r_state       <= START;
          end
        end

        START: begin
          ostorage_wash_enable <= 1'b1;
          r_state              <= WAIT;
        end

        WAIT: begin
          if (icorr_sample_ready) begin
            r_last               <= w_sample;
            onext_sample_trigger <= 1'b1;
            r_state              <= ACK;
            // Index 0 always seeds the tracker, so there is no sentinel.
            if ((r_cnt == '0) || w_new_max) begin
              opeak_index <= r_cnt[IDX_W-1:0];
              opeak_value <= w_sample;
              opeak_prev  <= (r_cnt == '0) ? '0 : r_last;
              opeak_next  <= '0;
              r_max_key   <= w_key;
              r_need_next <= 1'b1;
            end else if (r_need_next) begin
              opeak_next  <= w_sample;
              r_need_next <= 1'b0;
            end
          end else if ((r_to_cnt + 1'b1) == c_timeout) begin
            oerror               <= 1'b1;
            ostorage_wash_enable <= 1'b0;
            obusy                <= 1'b0;
            r_state              <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ACK: begin
          onext_sample_trigger <= 1'b0;
          r_cnt                <= r_cnt + 1'b1;
          r_state              <= GAP;
        end

        // Ready is deliberately ignored here so the buffer can drop it.
        GAP: begin
          if (r_cnt == c_nsamples) begin
            oall_acquired_trigg <= 1'b1;
            opeak_valid         <= 1'b1;
            r_state             <= DONE;
          end else begin
            r_to_cnt <= '0;
            r_state  <= WAIT;
          end
        end

        DONE: begin
          oall_acquired_trigg  <= 1'b0;
          opeak_valid          <= 1'b0;
          ostorage_wash_enable <= 1'b0;
          obusy                <= 1'b0;
          r_state              <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_corr_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_corr_reader
// Purpose  : Self-checking bench for rx_corr_reader: table of directed
//            acquisitions, randomized acquisitions against a peak model,
//            timeout, enable-freeze, re-trigger and mid-run reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_corr_reader;

  localparam int SAMPLE_W       = 32;
  localparam int NSAMPLES       = 128;
  localparam int IDX_W          = 7;
  localparam int TIMEOUT_CYCLES = 4096;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       en  = 1'b1;
  logic                       trig = 1'b0;
  logic [3:0]                 seq_in = '0;
  logic signed [SAMPLE_W-1:0] samp = '0;
  logic                       rdy = 1'b0;

  logic [3:0]                 rx_seq;
  logic                       wash, nxt, all_acq, busy, pvalid, err;
  logic [IDX_W-1:0]           pidx;
  logic signed [SAMPLE_W-1:0] pval, pprev, pnext;

  rx_corr_reader #(
    .SAMPLE_W(SAMPLE_W), .NSAMPLES(NSAMPLES),
    .IDX_W(IDX_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .crx_clk(clk), .rrx_rst(rst), .erx_en(en),
    .idetect_trigger(trig), .idetect_seq(seq_in),
    .icorr_sample(samp), .icorr_sample_ready(rdy),
    .oreceived_seq(rx_seq), .ostorage_wash_enable(wash),
    .onext_sample_trigger(nxt), .oall_acquired_trigg(all_acq),
    .obusy(busy), .opeak_valid(pvalid), .opeak_index(pidx),
    .opeak_value(pval), .opeak_prev(pprev), .opeak_next(pnext),
    .oerror(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse/cycle counters, sampled on the falling edge.
  int   ack_cycles = 0, ack_pulses = 0, all_pulses = 0, valid_pulses = 0;
  logic ack_q = 1'b0;
  always @(negedge clk) begin
    if (nxt === 1'b1) ack_cycles++;
    if (nxt === 1'b1 && ack_q !== 1'b1) ack_pulses++;
    ack_q = nxt;
    if (all_acq === 1'b1) all_pulses++;
    if (pvalid === 1'b1) valid_pulses++;
  end

  // Sample window presented by the buffer model.
  logic signed [SAMPLE_W-1:0] data [NSAMPLES];

  function automatic longint key_of(input longint s);
    longint a;
    a = s;
`ifdef RX_CORR_READER_ABS_EN
    if (a < 0) a = -a;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
`endif
    return a;
  endfunction

  // Reference peak: first index holding the largest key over the window.
  task automatic model_peak(output int e_idx, output longint e_val,
                            output longint e_prev, output longint e_next);
    e_idx = 0;
    for (int i = 1; i < NSAMPLES; i++)
      if (key_of(data[i]) > key_of(data[e_idx])) e_idx = i;
    e_val  = data[e_idx];
    e_prev = (e_idx == 0) ? 0 : data[e_idx-1];
    e_next = (e_idx == NSAMPLES-1) ? 0 : data[e_idx+1];
  endtask

  task automatic fill_pattern(input int p);
    for (int i = 0; i < NSAMPLES; i++) begin
      case (p)
        0: data[i] = i;
        1: data[i] = (i == 40 || i == 90) ? 100 : 5;
        2: data[i] = (i == 0) ? -1000 : 0;
        3: data[i] = 7;
        4: data[i] = 127 - i;
        5: data[i] = (i == 1) ? 50 : -3;
        6: data[i] = (i == 10) ? 32'sh8000_0000 : (i == 20) ? 32'sh7FFF_FFFF : 0;
        default: begin
          if ($urandom_range(0, 9) == 0) data[i] = $signed($urandom);
          else data[i] = $signed($urandom_range(0, 400)) - 200;
        end
      endcase
    end
  endtask

  // One acquisition. gap<0 picks a random 1..4 cycle ready delay after each
  // ack; en_k/rst_k/retrig_k (>=0) inject a freeze, reset or spurious
  // trigger at that sample.
  task automatic do_acq(input logic [3:0] s, input int gap, input int en_k,
                        input int rst_k, input int retrig_k,
                        output logic [IDX_W-1:0] r_idx,
                        output logic signed [SAMPLE_W-1:0] r_val,
                        output logic signed [SAMPLE_W-1:0] r_prev,
                        output logic signed [SAMPLE_W-1:0] r_next,
                        output bit completed);
    int a0, ap0, all0, v0, g;
    bit got;
    completed = 1'b0;
    r_idx = '0; r_val = '0; r_prev = '0; r_next = '0;
    a0 = ack_cycles; ap0 = ack_pulses; all0 = all_pulses; v0 = valid_pulses;
    @(negedge clk);
    seq_in = s; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0; seq_in = ~s;
    check("busy_t1", busy, 1);
    check("err_clear_on_trigger", err, 0);
    @(negedge clk);
    check("wash_t2", wash, 1);
    check("seq_t2", rx_seq, s);
    for (int k = 0; k < NSAMPLES; k++) begin
      if (k == rst_k) begin
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_clear",
              |{rx_seq, wash, nxt, all_acq, busy, pvalid, pidx, pval, pprev, pnext, err}, 0);
        rst = 1'b0;
        return;
      end
      g = (gap < 0) ? $urandom_range(1, 4) : gap;
      repeat (g) @(negedge clk);
      rdy = 1'b1; samp = data[k];
      if (k == retrig_k) begin trig = 1'b1; seq_in = s ^ 4'h5; end
      got = 1'b0;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        trig = 1'b0;
        if (nxt === 1'b1) got = 1'b1;
      end
      if (!got) begin
        check("ack_wait_expired", 0, 1);
        rdy = 1'b0;
        return;
      end
      rdy = 1'b0; samp = $signed($urandom);
      if (k == en_k) begin
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
      end
    end
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (all_acq === 1'b1) got = 1'b1;
    end
    if (!got) begin
      check("done_wait_expired", 0, 1);
      return;
    end
    check("valid_with_all", pvalid, 1);
    check("busy_in_done", busy, 1);
    check("wash_in_done", wash, 1);
    r_idx = pidx; r_val = pval; r_prev = pprev; r_next = pnext;
    @(negedge clk);
    check("idle_after_done", {all_acq, pvalid, busy, wash, nxt}, 0);
    check("peak_held", {pidx, pval, pprev, pnext}, {r_idx, r_val, r_prev, r_next});
    check("seq_held", rx_seq, s);
    check("ack_pulses", ack_pulses - ap0, NSAMPLES);
    check("ack_cycles", ack_cycles - a0, (en_k >= 0) ? NSAMPLES + 10 : NSAMPLES);
    check("all_pulses", all_pulses - all0, 1);
    check("valid_pulses", valid_pulses - v0, 1);
    completed = 1'b1;
  endtask

  typedef struct {
    logic [3:0] seq;
    int         pat;
    int         e_idx;
    longint     e_val;
    longint     e_prev;
    longint     e_next;
  } vec_t;

  initial begin
    vec_t tbl [7];
    logic [IDX_W-1:0] ri;
    logic signed [SAMPLE_W-1:0] rv, rp, rn;
    bit done;
    int e_idx, n, a0, v0;
    longint e_val, e_prev, e_next;

    tbl[0] = '{4'd15, 0, 127, 127, 126, 0};
    tbl[1] = '{4'd3,  1, 40, 100, 5, 5};
`ifdef RX_CORR_READER_ABS_EN
    tbl[2] = '{4'd9,  2, 0, -1000, 0, 0};
    tbl[6] = '{4'd1,  6, 10, -64'sd2147483648, 0, 0};
`else
    tbl[2] = '{4'd9,  2, 1, 0, -1000, 0};
    tbl[6] = '{4'd1,  6, 20, 64'sd2147483647, 0, 0};
`endif
    tbl[3] = '{4'd0,  3, 0, 7, 0, 7};
    tbl[4] = '{4'd6,  4, 0, 127, 0, 126};
    tbl[5] = '{4'd12, 5, 1, 50, -3, -3};

    repeat (3) @(negedge clk);
    check("rst_seq", rx_seq, 0);
    check("rst_wash", wash, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_valid", pvalid, 0);
    check("rst_all", all_acq, 0);
    check("rst_peak", {pidx, pval, pprev, pnext}, 0);
    rst = 1'b0;

    // Directed table, ready one cycle after each ack.
    for (int i = 0; i < 7; i++) begin
      fill_pattern(tbl[i].pat);
      do_acq(tbl[i].seq, 1, -1, -1, -1, ri, rv, rp, rn, done);
      if (done) begin
        check($sformatf("tbl%0d_idx", i), ri, tbl[i].e_idx);
        check($sformatf("tbl%0d_val", i), rv, tbl[i].e_val);
        check($sformatf("tbl%0d_prev", i), rp, tbl[i].e_prev);
        check($sformatf("tbl%0d_next", i), rn, tbl[i].e_next);
      end
    end

    // Timeout: ready never comes.
    a0 = all_pulses; v0 = valid_pulses;
    @(negedge clk);
    seq_in = 4'd3; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    n = 1;
    while (n < 5000 && err !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycle", n, 4098);
    check("timeout_wash", wash, 0);
    check("timeout_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("timeout_err_sticky", err, 1);
    check("timeout_no_valid", valid_pulses - v0, 0);
    check("timeout_no_all", all_pulses - a0, 0);

    // Randomized acquisitions against the model, with freeze and re-trigger.
    for (int r = 0; r < 5; r++) begin
      fill_pattern(99);
      model_peak(e_idx, e_val, e_prev, e_next);
      do_acq(4'($urandom_range(0, 15)), -1, (r == 1) ? 50 : -1, -1,
             (r == 2) ? 30 : -1, ri, rv, rp, rn, done);
      if (done) begin
        check($sformatf("rnd%0d_idx", r), ri, e_idx);
        check($sformatf("rnd%0d_val", r), rv, e_val);
        check($sformatf("rnd%0d_prev", r), rp, e_prev);
        check($sformatf("rnd%0d_next", r), rn, e_next);
      end
    end

    // Reset at sample 64, then a normal acquisition.
    fill_pattern(99);
    do_acq(4'd7, 1, -1, 64, -1, ri, rv, rp, rn, done);
    fill_pattern(99);
    model_peak(e_idx, e_val, e_prev, e_next);
    do_acq(4'd10, -1, -1, -1, -1, ri, rv, rp, rn, done);
    if (done) begin
      check("after_rst_idx", ri, e_idx);
      check("after_rst_val", rv, e_val);
      check("after_rst_prev", rp, e_prev);
      check("after_rst_next", rn, e_next);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
